// File: rtl/bist_pkg.sv
// Shared definitions for the full-adder BIST loop: ORA state encoding and MISR taps.
package bist_pkg;

    localparam int DEFAULT_SIG_WIDTH = 4;
    localparam int CNT_WIDTH         = 3;

    // Feedback from the MSB lands on bits 0 and 1: x^4 + x + 1.
    localparam logic [3:0] MISR_TAPS = 4'b0011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        COMPARE  = 2'd2,
        DONE     = 2'd3
    } ora_state_t;

endpackage

// File: rtl/bist_misr.sv
// 4-bit multiple-input signature register compacting a 2-bit response per enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int SIG_WIDTH = DEFAULT_SIG_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [SIG_WIDTH-1:0] seed,
    input  logic                 enable,
    input  logic [1:0]           data,
    output logic [SIG_WIDTH-1:0] signature
);

    logic [SIG_WIDTH-1:0] sig_q;
    logic [SIG_WIDTH-1:0] sig_d;
    logic [SIG_WIDTH-1:0] data_ext;
    logic                 feedback;

    assign feedback = sig_q[SIG_WIDTH-1];
    assign data_ext = {{(SIG_WIDTH-2){1'b0}}, data};

    // Each bit: shifted-in neighbour, tapped feedback, and its parallel response input.
    generate
        for (genvar gi = 0; gi < SIG_WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign sig_d[gi] = (MISR_TAPS[gi] & feedback) ^ data_ext[gi];
            end else begin : g_upper
                assign sig_d[gi] = sig_q[gi-1] ^ (MISR_TAPS[gi] & feedback) ^ data_ext[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else if (load) begin
            sig_q <= seed;
        end else if (enable) begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/bist_ora_misr.sv
// Output response analyzer: compacts NUM_PATTERNS CUT responses and compares to GOLDEN_SIG.
// Optional macro BIST_ORA_SIG_OBS_EN exposes the live MISR on the signature port.
module bist_ora_misr
    import bist_pkg::*;
#(
    parameter int                   SIG_WIDTH    = DEFAULT_SIG_WIDTH,
    parameter int                   NUM_PATTERNS = 7,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = '0,
    parameter logic [SIG_WIDTH-1:0] SEED         = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 resp_valid,
    input  logic                 resp_sum,
    input  logic                 resp_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
`ifdef BIST_ORA_SIG_OBS_EN
    ,
    output logic [SIG_WIDTH-1:0] signature
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_PATTERNS - 1);

    ora_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pass_q, pass_d;
    logic                 misr_load;
    logic                 misr_en;
    logic [SIG_WIDTH-1:0] misr_sig;

    bist_misr #(
        .SIG_WIDTH (SIG_WIDTH)
    ) u_misr (
        .clock     (clock),
        .reset     (reset),
        .load      (misr_load),
        .seed      (SEED),
        .enable    (misr_en),
        .data      ({resp_cout, resp_sum}),
        .signature (misr_sig)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            // DONE restarts exactly like IDLE so back-to-back tests need no idle cycle.
            IDLE, DONE: begin
                if (start) begin
                    state_d   = COMPRESS;
                    count_d   = '0;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end
            COMPRESS: begin
                if (resp_valid) begin
                    misr_en = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                state_d = DONE;
                pass_d  = (misr_sig == GOLDEN_SIG);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy = (state_q == COMPRESS) || (state_q == COMPARE);
    assign done = (state_q == DONE);
    assign pass = pass_q;

`ifdef BIST_ORA_SIG_OBS_EN
    assign signature = misr_sig;
`endif

endmodule

// File: tb/tb_bist_ora_misr.sv
// Directed bench for bist_ora_misr: three instances share stimulus, differing only in GOLDEN_SIG.
module tb_bist_ora_misr;
    import bist_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic resp_valid = 1'b0;
    logic resp_sum = 1'b0;
    logic resp_cout = 1'b0;
    logic busy_a, done_a, pass_a;
    logic busy_b, done_b, pass_b;
    logic busy_c, done_c, pass_c;
`ifdef BIST_ORA_SIG_OBS_EN
    logic [3:0] sig_a, sig_b, sig_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bist_ora_misr #(.SIG_WIDTH(4), .NUM_PATTERNS(7), .GOLDEN_SIG(4'b0000), .SEED(4'b0000)) dut_a (
        .clock(clock), .reset(reset), .start(start), .resp_valid(resp_valid),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy_a), .done(done_a), .pass(pass_a)
`ifdef BIST_ORA_SIG_OBS_EN
        , .signature(sig_a)
`endif
    );

    bist_ora_misr #(.SIG_WIDTH(4), .NUM_PATTERNS(7), .GOLDEN_SIG(4'b1100), .SEED(4'b0000)) dut_b (
        .clock(clock), .reset(reset), .start(start), .resp_valid(resp_valid),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy_b), .done(done_b), .pass(pass_b)
`ifdef BIST_ORA_SIG_OBS_EN
        , .signature(sig_b)
`endif
    );

    bist_ora_misr #(.SIG_WIDTH(4), .NUM_PATTERNS(7), .GOLDEN_SIG(4'b0110), .SEED(4'b0000)) dut_c (
        .clock(clock), .reset(reset), .start(start), .resp_valid(resp_valid),
        .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy_c), .done(done_c), .pass(pass_c)
`ifdef BIST_ORA_SIG_OBS_EN
        , .signature(sig_c)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input logic [1:0] r);
        resp_valid = 1'b1;
        resp_cout  = r[1];
        resp_sum   = r[0];
        step();
        resp_valid = 1'b0;
        resp_cout  = 1'b0;
        resp_sum   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass_a); end
        checks++; if (dut_a.misr_sig !== 4'b0000) begin errors++; $display("FAIL reset_misr got=%b exp=0000", dut_a.misr_sig); end
        checks++; if (dut_a.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut_a.state_q, IDLE); end
`ifdef BIST_ORA_SIG_OBS_EN
        checks++; if (sig_a !== 4'b0000) begin errors++; $display("FAIL reset_sig got=%b exp=0000", sig_a); end
`endif
        reset = 1'b1;
        step();
        $display("test_reset: busy=%b done=%b pass=%b", busy_a, done_a, pass_a);
    endtask

    task automatic test_zero_resp();
        do_start();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL zero_busy_rise got=%b exp=1", busy_a); end
        repeat (6) sample(2'b00);
        checks++; if (dut_a.state_q !== COMPRESS) begin errors++; $display("FAIL zero_still_compress got=%0d exp=%0d", dut_a.state_q, COMPRESS); end
        sample(2'b00);
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL zero_compare_cycle got done=%b busy=%b exp done=0 busy=1", done_a, busy_a); end
        step();
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL zero_done_rise got done=%b busy=%b exp done=1 busy=0", done_a, busy_a); end
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL zero_pass_g0 got=%b exp=1", pass_a); end
        checks++; if (pass_b !== 1'b0) begin errors++; $display("FAIL zero_pass_g1100 got=%b exp=0", pass_b); end
        checks++; if (dut_a.misr_sig !== 4'b0000) begin errors++; $display("FAIL zero_misr got=%b exp=0000", dut_a.misr_sig); end
        $display("test_zero_resp: misr=%b pass_a=%b pass_b=%b", dut_a.misr_sig, pass_a, pass_b);
    endtask

    task automatic test_single_one();
        logic [3:0] exp_seq [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC};
        do_start();
        for (int i = 0; i < 7; i++) begin
            sample((i == 0) ? 2'b01 : 2'b00);
            checks++; if (dut_b.misr_sig !== exp_seq[i]) begin errors++; $display("FAIL single_misr_%0d got=%b exp=%b", i, dut_b.misr_sig, exp_seq[i]); end
        end
        step();
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", done_b); end
        checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL single_pass_g1100 got=%b exp=1", pass_b); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL single_pass_g0 got=%b exp=0", pass_a); end
        // Responses presented in DONE must not disturb the held result.
        sample(2'b11);
        sample(2'b11);
        checks++; if (dut_b.misr_sig !== 4'hC || done_b !== 1'b1 || pass_b !== 1'b1) begin
            errors++; $display("FAIL single_done_hold got misr=%b done=%b pass=%b exp 1100/1/1", dut_b.misr_sig, done_b, pass_b);
        end
        $display("test_single_one: misr=%b pass_a=%b pass_b=%b", dut_b.misr_sig, pass_a, pass_b);
    endtask

    task automatic test_gaps();
        logic [3:0]  exp_seq [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC};
        logic [11:0] mask = 12'b1101_0100_1101;
        int k = 0;
        do_start();
        for (int c = 0; c < 12; c++) begin
            if (mask[c]) begin
                sample((k == 0) ? 2'b01 : 2'b00);
                k++;
            end else begin
                resp_valid = 1'b0;
                resp_cout  = 1'b1;
                resp_sum   = 1'b1;
                step();
                resp_cout  = 1'b0;
                resp_sum   = 1'b0;
                checks++; if (dut_b.misr_sig !== ((k == 0) ? 4'h0 : exp_seq[k-1])) begin
                    errors++; $display("FAIL gap_hold_c%0d got=%b exp=%b", c, dut_b.misr_sig, (k == 0) ? 4'h0 : exp_seq[k-1]);
                end
            end
        end
        checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL gap_compare_cycle got done=%b busy=%b exp 0/1", done_b, busy_b); end
        step();
        checks++; if (done_b !== 1'b1 || pass_b !== 1'b1 || dut_b.misr_sig !== 4'hC) begin
            errors++; $display("FAIL gap_result got done=%b pass=%b misr=%b exp 1/1/1100", done_b, pass_b, dut_b.misr_sig);
        end
        $display("test_gaps: samples=%0d misr=%b pass_b=%b", k, dut_b.misr_sig, pass_b);
    endtask

    task automatic test_back_to_back();
        do_start();
        sample(2'b01);
        sample(2'b00);
        sample(2'b00);
        start = 1'b1;
        sample(2'b00);
        start = 1'b0;
        checks++; if (dut_b.misr_sig !== 4'h8) begin errors++; $display("FAIL b2b_start_ignored_misr got=%b exp=1000", dut_b.misr_sig); end
        checks++; if (dut_b.count_q !== 3'd4) begin errors++; $display("FAIL b2b_start_ignored_count got=%0d exp=4", dut_b.count_q); end
        sample(2'b00);
        sample(2'b00);
        checks++; if (busy_b !== 1'b1 || dut_b.state_q !== COMPRESS) begin errors++; $display("FAIL b2b_six_samples got busy=%b state=%0d exp 1/%0d", busy_b, dut_b.state_q, COMPRESS); end
        sample(2'b00);
        step();
        checks++; if (done_b !== 1'b1 || pass_b !== 1'b1) begin errors++; $display("FAIL b2b_result got done=%b pass=%b exp 1/1", done_b, pass_b); end
        do_start();
        checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL b2b_restart_flags got done=%b busy=%b exp 0/1", done_b, busy_b); end
        checks++; if (dut_b.misr_sig !== 4'h0 || pass_b !== 1'b0) begin errors++; $display("FAIL b2b_restart_seed got misr=%b pass=%b exp 0000/0", dut_b.misr_sig, pass_b); end
        repeat (7) sample(2'b00);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (done_a !== 1'b1 || pass_a !== 1'b1 || dut_a.misr_sig !== 4'h0) begin
            errors++; $display("FAIL b2b_start_in_compare got done=%b pass=%b misr=%b exp 1/1/0000", done_a, pass_a, dut_a.misr_sig);
        end
        $display("test_back_to_back: done=%b pass_a=%b", done_a, pass_a);
    endtask

    task automatic test_reset_mid();
        do_start();
        sample(2'b01);
        sample(2'b00);
        sample(2'b00);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got busy=%b done=%b pass=%b exp 0/0/0", busy_b, done_b, pass_b);
        end
        checks++; if (dut_b.misr_sig !== 4'h0 || dut_b.count_q !== 3'd0 || dut_b.state_q !== IDLE) begin
            errors++; $display("FAIL midreset_state got misr=%b count=%0d state=%0d exp 0000/0/%0d", dut_b.misr_sig, dut_b.count_q, dut_b.state_q, IDLE);
        end
        step();
        reset = 1'b1;
        step();
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy=%b exp=0", busy_b); end
        do_start();
        sample(2'b01);
        repeat (6) sample(2'b00);
        step();
        checks++; if (done_b !== 1'b1 || pass_b !== 1'b1 || dut_b.misr_sig !== 4'hC) begin
            errors++; $display("FAIL midreset_rerun got done=%b pass=%b misr=%b exp 1/1/1100", done_b, pass_b, dut_b.misr_sig);
        end
        $display("test_reset_mid: misr=%b pass_b=%b", dut_b.misr_sig, pass_b);
    endtask

    task automatic run_fa_loop(input logic cout_stuck0);
        logic [2:0] tpg = 3'b001;
        logic a, b, ci, s, co;
        do_start();
        for (int i = 0; i < 7; i++) begin
            a  = tpg[2];
            b  = tpg[1];
            ci = tpg[0];
            s  = a ^ b ^ ci;
            co = cout_stuck0 ? 1'b0 : ((a & b) | (a & ci) | (b & ci));
            sample({co, s});
            tpg = {tpg[1:0], tpg[2] ^ tpg[1]};
        end
        step();
    endtask

    task automatic test_fa_loop();
        run_fa_loop(1'b0);
        checks++; if (dut_c.misr_sig !== 4'b0110) begin errors++; $display("FAIL fa_good_misr got=%b exp=0110", dut_c.misr_sig); end
        checks++; if (pass_c !== 1'b1 || done_c !== 1'b1) begin errors++; $display("FAIL fa_good_pass got pass=%b done=%b exp 1/1", pass_c, done_c); end
        checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL fa_good_pass_g0 got=%b exp=0", pass_a); end
`ifdef BIST_ORA_SIG_OBS_EN
        checks++; if (sig_c !== 4'b0110) begin errors++; $display("FAIL fa_good_sigport got=%b exp=0110", sig_c); end
`endif
        $display("test_fa_loop good: misr=%b pass_c=%b", dut_c.misr_sig, pass_c);
        run_fa_loop(1'b1);
        checks++; if (dut_c.misr_sig !== 4'b1111) begin errors++; $display("FAIL fa_sa0_misr got=%b exp=1111", dut_c.misr_sig); end
        checks++; if (pass_c !== 1'b0 || done_c !== 1'b1) begin errors++; $display("FAIL fa_sa0_pass got pass=%b done=%b exp 0/1", pass_c, done_c); end
        $display("test_fa_loop stuck-at-0 cout: misr=%b pass_c=%b", dut_c.misr_sig, pass_c);
    endtask

    initial begin
        test_reset();
        test_zero_resp();
        test_single_one();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_fa_loop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
